if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-to-decode pipeline stage: latches the instruction word and PC from instruction memory each cycle, splits the word into MIPS-style fields, and detects load-use hazards. It drives the stall back to instruction memory and a bubble request into ID/EX. It also applies branch flushes and the end-of-program halt. It sits between instruction memory (upstream) and the register file / ID/EX register (downstream).

## Interface
- `HALT_PC`, default 32'd100: fetch PC that ends the program.
- `clk` input 1: sole clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `inp_instn` input 32: instruction word from instruction memory.
- `pc_to_branch` input 32: PC of `inp_instn`.
- `branch_taken` input 1: EX resolved a taken branch/jump; flush.
- `id_ex_mem_read` input 1: instruction now in ID/EX is a load.
- `id_ex_rt` input 5: destination register of that load.
- `stall_flag` output 1: freeze request to instruction memory and PC.
- `bubble` output 1: ID/EX must load a NOP this cycle.
- `instn_out` output 32: latched instruction.
- `pc_out` output 32: latched PC.
- `valid_out` output 1: `instn_out` is a real instruction.
- `opcode`, `funct` outputs 6 each; `rs`, `rt`, `rd`, `shamt` outputs 5 each; `imm` output 16: field slices of `instn_out`.
- `halted` output 1: sticky end-of-program flag.

## Operation
- FSM states: RUN, STALL, HALT. Reset enters RUN.
- **RUN**
  - Hazard exists when `valid_out && id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == rs || id_ex_rt == rt)`.
  - Hazard: `stall_flag` = 1 and `bubble` = 1 combinationally. Latch holds its contents. Next state is STALL.
  - No hazard: latch loads `inp_instn` / `pc_to_branch` with `valid_out` = 1.
- **STALL**
  - Lasts exactly one cycle. `stall_flag` = 0 and `bubble` = 0.
  - Latch loads new fetch data. Next state is RUN.
- **Flush**
  - `branch_taken` = 1 in RUN or STALL: next `valid_out` = 0 and `instn_out` = 0. Next state is RUN.
  - Flush overrides a hazard raised in the same cycle; `stall_flag` is forced 0 that cycle.
- **Halt**
  - Triggered when `pc_to_branch == HALT_PC` is sampled while loading.
  - Effects: enter HALT, `halted` = 1, `valid_out` = 0.
  - `stall_flag` = 1 permanently. `branch_taken` is ignored.
  - Only `reset` leaves HALT.
- Field slices:
  - `opcode` = [31:26]
  - `rs` = [25:21]
  - `rt` = [20:16]
  - `rd` = [15:11]
  - `shamt` = [10:6]
  - `funct` = [5:0]
  - `imm` = [15:0]
- No arithmetic; PC is passed through unmodified at 32 bits.

## Timing
- Reset values:
  - `instn_out` = 0, `pc_out` = 0, `valid_out` = 0, `halted` = 0.
  - `stall_flag` = 0, `bubble` = 0, all fields 0.
- Reset in any state, including mid-stall or HALT, wins over every other input at that edge.
- Latency: fetch data is visible on `instn_out` one cycle after it is presented.
- `stall_flag` and `bubble` are combinational from latch state and ID/EX inputs, valid in the same cycle. Instruction memory samples `stall_flag` at the next rising edge.
- Load-use costs exactly one stall cycle. Back-to-back hazards re-stall only after passing through STALL.
- Halt takes effect at the edge that samples `HALT_PC`. `stall_flag` rises in the following cycle.

## Configuration
- `IF_ID_STATS_EN` defined:
  - Adds outputs `stall_count` [15:0] and `flush_count` [15:0].
  - Each is a saturating counter, reset to 0, incremented once per hazard stall cycle or per flush edge.
  - Counters freeze in HALT.
- `IF_ID_STATS_EN` undefined: ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the FSM state enum;
  - field bit-position constants;
  - `NOP_INSTN` = 32'd0;
  - the `instn_fields_t` struct.
- One sub-module, `load_use_detect`: combinational hazard compare over `rs`, `rt`, `id_ex_rt`, `id_ex_mem_read`, `valid_out`.
- The latch, FSM and optional counters stay in the top module.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs -> all outputs 0, state RUN.
- **Streaming:** present 0x012A4020 at PC 0x0, then 0x0 at PC 0x4 -> `instn_out` = 0x012A4020 with `rs` = 9, `rt` = 10, `rd` = 8, `funct` = 0x20 one cycle later, then PC 0x4.
- **Load-use:**
  - Setup: latched `rs` = 8, `id_ex_mem_read` = 1, `id_ex_rt` = 8.
  - Expect: `stall_flag` = `bubble` = 1 for one cycle and latch unchanged.
  - Repeat with `id_ex_rt` = 0 -> no stall.
- **Flush:**
  - Stimulus: `branch_taken` = 1 in the same cycle as a load-use hazard.
  - Expect: `stall_flag` = 0 that cycle, next `valid_out` = 0 and `instn_out` = 0.
- **Halt:**
  - Stimulus: `pc_to_branch` = 100 -> `halted` = 1 and `stall_flag` = 1 held for 10 cycles despite `branch_taken` pulses.
  - Then `reset` -> RUN with outputs cleared.
- **Stats (with `IF_ID_STATS_EN`):** 3 hazards and 2 flushes -> `stall_count` = 3, `flush_count` = 2; forced 0xFFFF + 1 stays 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline: stage FSM states,
// MIPS instruction field positions, the NOP encoding and a field-split helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } stage_state_t;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] NOP_INSTN = 32'd0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instn_fields_t;

    function automatic instn_fields_t split_instn(input logic [31:0] instn);
        instn_fields_t f;
        f.opcode = instn[OPCODE_LSB +: 6];
        f.rs     = instn[RS_LSB     +: 5];
        f.rt     = instn[RT_LSB     +: 5];
        f.rd     = instn[RD_LSB     +: 5];
        f.shamt  = instn[SHAMT_LSB  +: 5];
        f.funct  = instn[FUNCT_LSB  +: 6];
        f.imm    = instn[IMM_LSB    +: 16];
        return f;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between instruction memory / EX feedback and the IF/ID stage.
// Optional statistics outputs appear when IF_ID_STATS_EN is defined.
interface if_id_stage_if;
    logic [31:0] inp_instn;
    logic [31:0] pc_to_branch;
    logic        branch_taken;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;

    logic        stall_flag;
    logic        bubble;
    logic [31:0] instn_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        halted;
`ifdef IF_ID_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    modport slave (
        input  inp_instn, pc_to_branch, branch_taken, id_ex_mem_read, id_ex_rt,
        output stall_flag, bubble, instn_out, pc_out, valid_out,
        output opcode, funct, rs, rt, rd, shamt, imm, halted
`ifdef IF_ID_STATS_EN
        , output stall_count, flush_count
`endif
    );

    modport master (
        output inp_instn, pc_to_branch, branch_taken, id_ex_mem_read, id_ex_rt,
        input  stall_flag, bubble, instn_out, pc_out, valid_out,
        input  opcode, funct, rs, rt, rd, shamt, imm, halted
`ifdef IF_ID_STATS_EN
        , input stall_count, flush_count
`endif
    );
endinterface

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register the latched
// instruction reads. Register 0 never creates a dependency.
module load_use_detect (
    input  logic       valid_out,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    output logic       hazard
);
    always_comb begin
        hazard = valid_out && id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == rs) || (id_ex_rt == rt));
    end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and halt FSM.
// Define IF_ID_STATS_EN to add saturating stall/flush counters.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] HALT_PC = 32'd100
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.slave  bus
);
    stage_state_t  state_reg, state_next;
    logic [31:0]   instn_reg, instn_next;
    logic [31:0]   pc_reg, pc_next;
    logic          valid_reg, valid_next;
    logic          hazard;
    logic          stall_int;
    logic          bubble_int;
    logic          load;
    logic          stall_event;
    logic          flush_event;
    instn_fields_t fields;

    assign fields = split_instn(instn_reg);

    load_use_detect u_detect (
        .valid_out      (valid_reg),
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .rs             (fields.rs),
        .rt             (fields.rt),
        .hazard         (hazard)
    );

    always_comb begin
        state_next  = state_reg;
        instn_next  = instn_reg;
        pc_next     = pc_reg;
        valid_next  = valid_reg;
        stall_int   = 1'b0;
        bubble_int  = 1'b0;
        load        = 1'b0;
        flush_event = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                bubble_int = hazard;
                if (bus.branch_taken) begin
                    flush_event = 1'b1;
                end else if (hazard) begin
                    stall_int  = 1'b1;
                    state_next = ST_STALL;
                end else begin
                    load = 1'b1;
                end
            end
            ST_STALL: begin
                if (bus.branch_taken) begin
                    flush_event = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
            ST_HALT: begin
                stall_int = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (flush_event) begin
            instn_next = NOP_INSTN;
            valid_next = 1'b0;
            state_next = ST_RUN;
        end

        // The halt PC is the end marker, not an instruction to execute.
        if (load) begin
            pc_next = bus.pc_to_branch;
            if (bus.pc_to_branch == HALT_PC) begin
                instn_next = NOP_INSTN;
                valid_next = 1'b0;
                state_next = ST_HALT;
            end else begin
                instn_next = bus.inp_instn;
                valid_next = 1'b1;
                state_next = ST_RUN;
            end
        end

        stall_event = stall_int && (state_reg == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
            instn_reg <= NOP_INSTN;
            pc_reg    <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            instn_reg <= instn_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.stall_flag = stall_int;
    assign bus.bubble     = bubble_int;
    assign bus.instn_out  = instn_reg;
    assign bus.pc_out     = pc_reg;
    assign bus.valid_out  = valid_reg;
    assign bus.opcode     = fields.opcode;
    assign bus.funct      = fields.funct;
    assign bus.rs         = fields.rs;
    assign bus.rt         = fields.rt;
    assign bus.rd         = fields.rd;
    assign bus.shamt      = fields.shamt;
    assign bus.imm        = fields.imm;
    assign bus.halted     = (state_reg == ST_HALT);

`ifdef IF_ID_STATS_EN
    // Index 0 counts hazard stall cycles, index 1 counts flush edges.
    logic [15:0] cnt_reg [2];
    logic [1:0]  cnt_inc;

    assign cnt_inc = {flush_event, stall_event};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg[gi] <= 16'd0;
            end else if (cnt_inc[gi] && (state_reg != ST_HALT) &&
                         (cnt_reg[gi] != 16'hFFFF)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
        end
    end

    assign bus.stall_count = cnt_reg[0];
    assign bus.flush_count = cnt_reg[1];
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized check of if_id_stage against a behavioural pipeline model,
// preceded by directed streaming, load-use, flush and halt scenarios.
module tb_if_id_stage;
    localparam logic [31:0] HALT_PC = 32'd100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_stage_if bus_if();
    if_id_stage #(.HALT_PC(HALT_PC)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: what the decode latch should hold and whether we halted.
    logic [31:0] m_instn;
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_halt;
    bit          m_just_stalled;
    bit          last_stall;
    int          m_scnt;
    int          m_fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_hazard();
        logic [4:0] r;
        r = bus_if.id_ex_rt;
        return !m_halt && !m_just_stalled && m_valid && bus_if.id_ex_mem_read &&
               (r != 5'd0) && (r == m_instn[25:21] || r == m_instn[20:16]);
    endfunction

    function automatic bit m_stall();
        return m_halt || (m_hazard() && !bus_if.branch_taken);
    endfunction

    task automatic cmp_all();
        check("stall_flag", {31'd0, bus_if.stall_flag}, {31'd0, m_stall()});
        check("bubble",     {31'd0, bus_if.bubble},     {31'd0, m_hazard()});
        check("instn_out",  bus_if.instn_out, m_instn);
        check("pc_out",     bus_if.pc_out,    m_pc);
        check("valid_out",  {31'd0, bus_if.valid_out}, {31'd0, m_valid});
        check("halted",     {31'd0, bus_if.halted},    {31'd0, m_halt});
        check("opcode", {26'd0, bus_if.opcode}, {26'd0, m_instn[31:26]});
        check("rs",     {27'd0, bus_if.rs},     {27'd0, m_instn[25:21]});
        check("rt",     {27'd0, bus_if.rt},     {27'd0, m_instn[20:16]});
        check("rd",     {27'd0, bus_if.rd},     {27'd0, m_instn[15:11]});
        check("shamt",  {27'd0, bus_if.shamt},  {27'd0, m_instn[10:6]});
        check("funct",  {26'd0, bus_if.funct},  {26'd0, m_instn[5:0]});
        check("imm",    {16'd0, bus_if.imm},    {16'd0, m_instn[15:0]});
`ifdef IF_ID_STATS_EN
        check("stall_count", {16'd0, bus_if.stall_count}, m_scnt);
        check("flush_count", {16'd0, bus_if.flush_count}, m_fcnt);
`endif
    endtask

    // Advance the model over one rising edge using the inputs held there.
    task automatic model_step();
        bit hz;
        hz = m_hazard();
        if (reset) begin
            m_instn = 32'd0; m_pc = 32'd0; m_valid = 0; m_halt = 0;
            m_just_stalled = 0; m_scnt = 0; m_fcnt = 0;
        end else if (!m_halt) begin
            if (bus_if.branch_taken) begin
                m_instn = 32'd0; m_valid = 0; m_just_stalled = 0;
                if (m_fcnt < 65535) m_fcnt++;
            end else if (hz) begin
                m_just_stalled = 1;
                if (m_scnt < 65535) m_scnt++;
            end else begin
                m_just_stalled = 0;
                m_pc = bus_if.pc_to_branch;
                if (bus_if.pc_to_branch == HALT_PC) begin
                    m_halt = 1; m_valid = 0; m_instn = 32'd0;
                end else begin
                    m_instn = bus_if.inp_instn; m_valid = 1;
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input logic [31:0] instn, input logic [31:0] pc,
                         input bit br, input bit mr, input logic [4:0] rt);
        reset                 = rst;
        bus_if.inp_instn      = instn;
        bus_if.pc_to_branch   = pc;
        bus_if.branch_taken   = br;
        bus_if.id_ex_mem_read = mr;
        bus_if.id_ex_rt       = rt;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        last_stall = m_stall();
        $display("cyc %0d rst=%b pc_in=%h br=%b | pc=%h instn=%h v=%b stall=%b bub=%b halt=%b",
                 cyc, reset, bus_if.pc_to_branch, bus_if.branch_taken, bus_if.pc_out,
                 bus_if.instn_out, bus_if.valid_out, bus_if.stall_flag, bus_if.bubble,
                 bus_if.halted);
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    localparam logic [31:0] ADD_RS8 = 32'h01095020; // add $10,$8,$9

    initial begin
        logic [31:0] cur_instn;
        logic [31:0] cur_pc;
        logic [31:0] next_pc;
        int          halt_cycles;
        bit          rst_r;
        bit          br_r;

        // Reset with random inputs on two edges.
        drive(1, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom));
        @(posedge clk);
        model_step();
        #1;
        drive(1, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom));
        tick();
        check("rst_instn", bus_if.instn_out, 32'd0);
        check("rst_pc", bus_if.pc_out, 32'd0);
        check("rst_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check("rst_halted", {31'd0, bus_if.halted}, 32'd0);

        // Streaming.
        drive(0, 32'h012A4020, 32'h0, 0, 0, 5'd0);
        tick();
        check("stream_instn", bus_if.instn_out, 32'h012A4020);
        check("stream_rs", {27'd0, bus_if.rs}, 32'd9);
        check("stream_rt", {27'd0, bus_if.rt}, 32'd10);
        check("stream_rd", {27'd0, bus_if.rd}, 32'd8);
        check("stream_funct", {26'd0, bus_if.funct}, 32'h20);
        check("stream_valid", {31'd0, bus_if.valid_out}, 32'd1);
        drive(0, 32'h0, 32'h4, 0, 0, 5'd0);
        tick();
        check("stream_pc", bus_if.pc_out, 32'h4);

        // Load-use on rs = 8.
        drive(0, ADD_RS8, 32'h8, 0, 0, 5'd0);
        tick();
        drive(0, 32'h0, 32'hC, 0, 1, 5'd8);
        #1;
        check("lu_stall", {31'd0, bus_if.stall_flag}, 32'd1);
        check("lu_bubble", {31'd0, bus_if.bubble}, 32'd1);
        tick();
        check("lu_hold_instn", bus_if.instn_out, ADD_RS8);
        check("lu_hold_pc", bus_if.pc_out, 32'h8);
        check("lu_one_cycle", {31'd0, bus_if.stall_flag}, 32'd0);
        tick();
        check("lu_resume_pc", bus_if.pc_out, 32'hC);

        // Load targeting $0 is never a hazard.
        drive(0, ADD_RS8, 32'h10, 0, 0, 5'd0);
        tick();
        drive(0, 32'h0, 32'h14, 0, 1, 5'd0);
        #1;
        check("r0_no_stall", {31'd0, bus_if.stall_flag}, 32'd0);
        tick();
        check("r0_pc", bus_if.pc_out, 32'h14);

        // Flush beats a same-cycle hazard.
        drive(0, ADD_RS8, 32'h18, 0, 0, 5'd0);
        tick();
        drive(0, 32'h1234, 32'h1C, 1, 1, 5'd8);
        #1;
        check("flush_stall0", {31'd0, bus_if.stall_flag}, 32'd0);
        tick();
        check("flush_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check("flush_instn", bus_if.instn_out, 32'd0);

        // Halt is sticky despite branch pulses.
        drive(0, $urandom, HALT_PC, 0, 0, 5'd0);
        tick();
        check("halt_flag", {31'd0, bus_if.halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(0, $urandom, $urandom, i % 2, $urandom_range(0, 1), 5'($urandom));
            #1;
            check("halt_stall", {31'd0, bus_if.stall_flag}, 32'd1);
            check("halt_hold", {31'd0, bus_if.halted}, 32'd1);
            tick();
        end
        drive(1, $urandom, $urandom, 1, 1, 5'($urandom));
        tick();
        check("halt_rst_halted", {31'd0, bus_if.halted}, 32'd0);
        check("halt_rst_stall", {31'd0, bus_if.stall_flag}, 32'd0);
        check("halt_rst_instn", bus_if.instn_out, 32'd0);

        // Randomized run: fetch stream from PC 0, memory freezes on stall.
        next_pc     = 32'd0;
        cur_instn   = 32'd0;
        cur_pc      = 32'd0;
        halt_cycles = 0;
        last_stall  = 0;
        for (int i = 0; i < 1500; i++) begin
            halt_cycles = m_halt ? halt_cycles + 1 : 0;
            rst_r = ($urandom_range(0, 199) == 0) || (halt_cycles >= 8);
            if (!last_stall || m_halt) begin
                cur_instn = {6'($urandom), 3'd0, 2'($urandom), 3'd0, 2'($urandom), 16'($urandom)};
                cur_pc    = next_pc;
                next_pc   = next_pc + 32'd4;
            end
            br_r = ($urandom_range(0, 9) == 0);
            if (br_r) next_pc = 32'($urandom_range(0, 30)) * 32'd4;
            if (rst_r) next_pc = 32'd0;
            drive(rst_r, cur_instn, cur_pc, br_r, $urandom_range(0, 1), 5'($urandom_range(0, 3)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
